// File: rtl/cdc_pulse_sched.sv
// Round-robin pulse scheduler: queues per-requester events and issues spaced
// one-cycle pulses with a stable tag. Optional ovf_o via CDC_PULSE_SCHED_OVF_EN.
module cdc_pulse_sched #(
    parameter int pN           = 4,
    parameter int pCNT_WIDTH   = 4,
    parameter int pHOLD_WIDTH  = 8,
    parameter int pMIN_HOLDOFF = 8,
    localparam int TW          = (pN > 1) ? $clog2(pN) : 1
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic [pN-1:0]          req_i,
    input  logic [pHOLD_WIDTH-1:0] holdoff_i,
    output logic                   chan_pulse_o,
    output logic [TW-1:0]          chan_tag_o,
    output logic [pN-1:0]          pending_o,
    output logic                   busy_o
`ifdef CDC_PULSE_SCHED_OVF_EN
    ,
    output logic [pN-1:0]          ovf_o
`endif
);

    localparam int MINW = $clog2(pMIN_HOLDOFF + 1);
    localparam int HW   = (pHOLD_WIDTH > MINW) ? pHOLD_WIDTH : MINW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t          state_q;
    logic [pN-1:0]   req_q;
    logic [TW-1:0]   tag_q, last_q, sel_d;
    logic            pulse_q;
    logic [HW-1:0]   hold_q, hold_ld;
    logic [pN-1:0]   nz, sat_hit, dec_vec;
    logic            grant_en, found;
    logic [TW:0]     rr_idx;

    // Requests are captured once so counters and arbitration see a clean,
    // registered view of the requester bus.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) req_q <= '0;
        else         req_q <= req_i;
    end

    for (genvar i = 0; i < pN; i++) begin : g_lane
        logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                  sat;

        assign sat = &cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (req_q[i] && dec_vec[i])  cnt_d = cnt_q;
            else if (req_q[i] && !sat)   cnt_d = cnt_q + pCNT_WIDTH'(1);
            else if (dec_vec[i])         cnt_d = cnt_q - pCNT_WIDTH'(1);
        end

        always_ff @(posedge clk or posedge reset_i) begin
            if (reset_i) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end

        assign nz[i]      = |cnt_q;
        assign sat_hit[i] = req_q[i] && sat && !dec_vec[i];
    end

    // First non-zero counter after the last grant, wrapping modulo pN.
    always_comb begin
        sel_d  = last_q;
        found  = 1'b0;
        rr_idx = '0;
        for (int k = 1; k <= pN; k++) begin
            rr_idx = {1'b0, last_q} + (TW+1)'(k);
            if (rr_idx >= (TW+1)'(pN)) rr_idx = rr_idx - (TW+1)'(pN);
            if (!found && nz[rr_idx[TW-1:0]]) begin
                found = 1'b1;
                sel_d = rr_idx[TW-1:0];
            end
        end
    end

    assign grant_en = (state_q == S_IDLE) && (|nz);

    always_comb begin
        dec_vec = '0;
        for (int i = 0; i < pN; i++)
            dec_vec[i] = grant_en && (sel_d == TW'(i));
    end

    assign hold_ld = (HW'(holdoff_i) > HW'(pMIN_HOLDOFF)) ? HW'(holdoff_i) : HW'(pMIN_HOLDOFF);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
            tag_q   <= '0;
            last_q  <= TW'(pN - 1);
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_en) begin
                        tag_q   <= sel_d;
                        last_q  <= sel_d;
                        pulse_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pulse_q <= 1'b0;
                    hold_q  <= hold_ld;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // hold_q is never zero here since the floor is at least 1
                    hold_q <= hold_q - HW'(1);
                    if (hold_q <= HW'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chan_pulse_o = pulse_q;
    assign chan_tag_o   = tag_q;
    assign pending_o    = nz;
    assign busy_o       = (state_q != S_IDLE);

`ifdef CDC_PULSE_SCHED_OVF_EN
    logic [pN-1:0] ovf_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) ovf_q <= '0;
        else         ovf_q <= ovf_q | sat_hit;
    end

    assign ovf_o = ovf_q;
`else
    logic sat_unused;
    assign sat_unused = |sat_hit;
`endif

endmodule

// File: tb/tb_cdc_pulse_sched.sv
// Scoreboard bench for cdc_pulse_sched: stimulus pushes expected pulses
// (tag, cycle); a negedge monitor pops and compares each observed pulse.
module tb_cdc_pulse_sched;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [3:0] req_i = '0;
    logic [7:0] holdoff_i = '0;
    logic       chan_pulse_o;
    logic [1:0] chan_tag_o;
    logic [3:0] pending_o;
    logic       busy_o;
`ifdef CDC_PULSE_SCHED_OVF_EN
    logic [3:0] ovf_o;
`endif

    cdc_pulse_sched #(
        .pN(4), .pCNT_WIDTH(4), .pHOLD_WIDTH(8), .pMIN_HOLDOFF(8)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .req_i(req_i),
        .holdoff_i(holdoff_i),
        .chan_pulse_o(chan_pulse_o),
        .chan_tag_o(chan_tag_o),
        .pending_o(pending_o),
        .busy_o(busy_o)
`ifdef CDC_PULSE_SCHED_OVF_EN
        ,
        .ovf_o(ovf_o)
`endif
    );

    typedef struct {
        int tag;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset_i && chan_pulse_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: actual tag %0d at cycle %0d, required none", chan_tag_o, cyc);
            end else begin
                m_e = sb.pop_front();
                chk("pulse_tag", int'(chan_tag_o), m_e.tag);
                chk("pulse_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic push_exp(input int tag, input int c);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Returns e = cycle number after the edge that first samples v.
    task automatic req_on(input logic [3:0] v, output int e);
        @(negedge clk);
        req_i = v;
        e = cyc + 1;
    endtask

    task automatic req_off(input int n);
        repeat (n) @(posedge clk);
        #1 req_i = '0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, (sb.size() == 0 && !busy_o) ? 1 : 0, 1);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int nb;
        int bad;
        logic [1:0] prev;

        // Reset state
        #1 reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse", int'(chan_pulse_o), 0);
        chk("reset_tag", int'(chan_tag_o), 0);
        chk("reset_pending", int'(pending_o), 0);
        chk("reset_busy", int'(busy_o), 0);
`ifdef CDC_PULSE_SCHED_OVF_EN
        chk("reset_ovf", int'(ovf_o), 0);
`endif
        @(negedge clk);
        reset_i = 1'b0;

        // Single event on requester 2, hold-off 20
        holdoff_i = 8'd20;
        req_on(4'b0100, e);
        push_exp(2, e + 2);
        req_off(1);
        @(posedge clk); #1;
        chk("single_pending_set", int'(pending_o), 4);
        @(posedge clk); #1;
        chk("single_pending_clear", int'(pending_o), 0);
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o) nb++;
        end
        chk("single_busy_cycles", nb, 21);
        chk("single_tag_held", int'(chan_tag_o), 2);
        wait_drain("single_drain", 50);

        // Round robin with hold-off below the floor
        do_reset();
        holdoff_i = 8'd0;
        req_on(4'b1111, e);
        for (int k = 0; k < 4; k++) push_exp(k, e + 2 + 10 * k);
        req_off(1);
        prev = chan_tag_o;
        bad = 0;
        repeat (45) begin
            @(negedge clk);
            if (chan_tag_o != prev && !chan_pulse_o) bad++;
            prev = chan_tag_o;
        end
        chk("rr_tag_glitches", bad, 0);
        chk("rr_final_tag", int'(chan_tag_o), 3);
        wait_drain("rr_drain", 50);

        // Saturation: 20 requests on requester 1, hold-off 30
        do_reset();
        holdoff_i = 8'd30;
        req_on(4'b0010, e);
        for (int k = 0; k < 16; k++) push_exp(1, e + 2 + 32 * k);
        req_off(20);
        wait_drain("sat_drain", 700);
        repeat (40) @(negedge clk);
        chk("sat_pending_empty", int'(pending_o), 0);
`ifdef CDC_PULSE_SCHED_OVF_EN
        chk("sat_ovf", int'(ovf_o), 2);
`endif

        // Increment coinciding with the grant decrement
        do_reset();
        holdoff_i = 8'd0;
        req_on(4'b0001, e);
        push_exp(0, e + 2);
        push_exp(0, e + 12);
        req_off(2);
        @(posedge clk); #1;
        chk("incdec_pending_kept", int'(pending_o), 1);
        wait_drain("incdec_drain", 60);
        chk("incdec_pending_final", int'(pending_o), 0);

        // Hold-off is sampled only at ISSUE
        do_reset();
        holdoff_i = 8'd40;
        req_on(4'b0001, e);
        push_exp(0, e + 2);
        push_exp(0, e + 44);
        push_exp(0, e + 54);
        req_off(3);
        repeat (12) @(posedge clk);
        #1 holdoff_i = 8'd5;
        wait_drain("holdoff_drain", 200);

        // Asynchronous reset in HOLD with backlog
        do_reset();
        holdoff_i = 8'd20;
        req_on(4'b1000, e);
        push_exp(3, e + 2);
        req_off(4);
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_busy", int'(busy_o), 1);
        chk("pre_reset_pending", int'(pending_o), 8);
        reset_i = 1'b1;
        #1;
        chk("async_busy", int'(busy_o), 0);
        chk("async_pending", int'(pending_o), 0);
        chk("async_tag", int'(chan_tag_o), 0);
        chk("async_pulse", int'(chan_pulse_o), 0);
        @(negedge clk);
        reset_i = 1'b0;
        sb.delete();
        repeat (50) @(negedge clk);
        chk("post_reset_idle", int'(busy_o), 0);
        req_on(4'b0001, e);
        push_exp(0, e + 2);
        req_off(1);
        wait_drain("post_reset_drain", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
